// File: rtl/data_mem_pipe.sv
// Byte-lane data memory for the MEM stage: registered load responses, alignment/range
// fault detection, and a hardware zero-fill sweep after reset.

`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`define DM_OP_WD  3'd0
`define DM_OP_UH  3'd1
`define DM_OP_SH  3'd2
`define DM_OP_UB  3'd3
`define DM_OP_SB  3'd4
`endif

module data_mem_pipe #(
  parameter int ADDR_BITS  = 10,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [`DM_OP_BIT-1:0] op,
  input  logic                  w_en,
  input  logic [31:0]           addr,
  input  logic [31:0]           data_in,
  output logic                  ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  fault,
  input  logic [31:0]           addr_dbg,
  output logic [31:0]           data_dbg
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                 state_q;
  logic [ADDR_BITS-1:0]   cnt_q;
  logic                   ready_q;
  logic                   rsp_valid_q;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic                   fault_q;

  // Lane 0 = byte 0 (bits 7:0) ... lane 3 = byte 3 (bits 31:24).
  logic [7:0]             mem_q [4][DEPTH];

  logic                   accept;
  logic [ADDR_BITS-1:0]   idx;
  logic [1:0]             off;
  logic                   is_wd, is_half, is_byte, is_signed, op_legal;
  logic                   range_err, fault_c;
  logic [31:0]            rd_word;
  logic [7:0]             rd_byte;
  logic [15:0]            rd_half;
  logic [3:0]             st_mask;
  logic [31:0]            st_data;
  logic [3:0]             lane_we;
  logic [ADDR_BITS-1:0]   wr_idx;
  logic [31:0]            wr_data;
  logic [ADDR_BITS-1:0]   dbg_idx;
  logic                   unused_dbg;

  assign accept = req & ready_q;
  assign idx    = addr[ADDR_BITS+1:2];
  assign off    = addr[1:0];

  // ---------------------------------------------------------------------------
  // Request decode and fault detection
  // ---------------------------------------------------------------------------
  always_comb begin
    is_wd     = 1'b0;
    is_half   = 1'b0;
    is_byte   = 1'b0;
    is_signed = 1'b0;
    op_legal  = 1'b1;
    case (op)
      `DM_OP_WD: is_wd = 1'b1;
      `DM_OP_UH: is_half = 1'b1;
      `DM_OP_SH: begin is_half = 1'b1; is_signed = 1'b1; end
      `DM_OP_UB: is_byte = 1'b1;
      `DM_OP_SB: begin is_byte = 1'b1; is_signed = 1'b1; end
      default:   op_legal = 1'b0;
    endcase
  end

  assign range_err = (addr >> (ADDR_BITS + 2)) != 32'd0;
  assign fault_c   = range_err | ~op_legal | (is_wd & (off != 2'b00)) | (is_half & off[0]);

  // ---------------------------------------------------------------------------
  // Load extraction from the addressed word
  // ---------------------------------------------------------------------------
  assign rd_word = {mem_q[3][idx], mem_q[2][idx], mem_q[1][idx], mem_q[0][idx]};
  assign rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];
  assign rd_byte = rd_word[{off, 3'b000} +: 8];

  // NOTE: every output of a combinational block gets a default first so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    rsp_data_d = 32'd0;
    if (!fault_c && !w_en) begin
      if (is_wd)        rsp_data_d = rd_word;
      else if (is_half) rsp_data_d = {{16{is_signed & rd_half[15]}}, rd_half};
      else if (is_byte) rsp_data_d = {{24{is_signed & rd_byte[7]}}, rd_byte};
    end
  end

  // ---------------------------------------------------------------------------
  // Store lane mask and lane-replicated write data
  // ---------------------------------------------------------------------------
  always_comb begin
    st_mask = 4'b0000;
    st_data = data_in;
    if (is_wd) begin
      st_mask = 4'b1111;
    end else if (is_half) begin
      st_mask = off[1] ? 4'b1100 : 4'b0011;
      st_data = {2{data_in[15:0]}};
    end else if (is_byte) begin
      st_mask = 4'b0001 << off;
      st_data = {4{data_in[7:0]}};
    end
  end

  // Array write port shared by the init sweep and accepted stores; nothing is
  // written on an edge where reset is sampled low.
  always_comb begin
    lane_we = 4'b0000;
    wr_idx  = idx;
    wr_data = st_data;
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        if (INIT_CLEAR) begin
          lane_we = 4'b1111;
          wr_idx  = cnt_q;
          wr_data = 32'd0;
        end
      end else if (accept && w_en && !fault_c) begin
        lane_we = st_mask;
      end
    end
  end

  // NOTE: the storage array has no reset term; clearing is done by the INIT
  // sweep, which keeps the lanes mappable onto plain RAM macros.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (lane_we[l]) mem_q[l][wr_idx] <= wr_data[8*l +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // Init/run FSM
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (!INIT_CLEAR || (&cnt_q)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers: pulse valid, hold data/fault while idle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      fault_q     <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_data_q <= rsp_data_d;
        fault_q    <= fault_c;
      end
    end
  end

  assign ready     = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign fault     = fault_q;

  // Debug view ignores the byte offset and wraps on the upper address bits.
  assign dbg_idx    = addr_dbg[ADDR_BITS+1:2];
  assign data_dbg   = {mem_q[3][dbg_idx], mem_q[2][dbg_idx], mem_q[1][dbg_idx], mem_q[0][dbg_idx]};
  assign unused_dbg = ^{addr_dbg[31:ADDR_BITS+2], addr_dbg[1:0]};

endmodule

// File: doc/data_mem_pipe.md
# data_mem_pipe

Parametrised, byte-lane data memory with synchronous (registered) reads, a request/response handshake, alignment and range checking, and hardware zero-initialisation after reset. It sits in the core's MEM stage in place of the combinational data memory. It serves word, halfword and byte loads/stores (signed and unsigned) through four byte lanes. A side debug port gives a combinational word view for the display logic.

## Interface
- ADDR_BITS, 10: word-address bits; depth = 2^ADDR_BITS words (4·2^ADDR_BITS bytes)
- INIT_CLEAR, 1: 1 = zero every word after reset; 0 = skip clearing
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  1  request valid; accepted when req && ready
- op  in  `DM_OP_BIT  access type: `DM_OP_WD, `DM_OP_UH, `DM_OP_SH, `DM_OP_UB, `DM_OP_SB
- w_en  in  1  1 = store, 0 = load
- addr  in  32  byte address
- data_in  in  32  store data, low bits used for half/byte
- ready  out  1  block can accept a request this cycle
- rsp_valid  out  1  one-cycle pulse, response for the request accepted in the previous cycle
- rsp_data  out  32  load result, zero/sign-extended per op; 0 for stores and faults
- fault  out  1  qualified by rsp_valid; misaligned, out-of-range or illegal op
- addr_dbg  in  32  byte address for debug read
- data_dbg  out  32  word at addr_dbg[ADDR_BITS+1:2], combinational

## Operation
- Storage: four byte lanes, each 2^ADDR_BITS × 8. Lane a = byte 0 (bits 7:0) through lane d = byte 3 (bits 31:24), little-endian.
- Word index = addr[ADDR_BITS+1:2]. Byte offset = addr[1:0].
- FSM states: INIT and RUN.
  - Reset enters INIT and clears the counter to 0.
  - INIT with INIT_CLEAR=1: writes 0 to all four lanes at the counter index each cycle, then increments. After writing index 2^ADDR_BITS−1, goes to RUN.
  - INIT with INIT_CLEAR=0: goes to RUN after one cycle, no writes.
  - RUN: ready=1. Stays in RUN until reset.
- ready=0 in INIT. req while ready=0 is ignored, with no response.
- Fault conditions, checked on accept:
  - addr[31:ADDR_BITS+2] ≠ 0
  - UH/SH with addr[0]=1
  - WD with addr[1:0]≠0
  - op not one of the five codes
- On fault: no lane is written, rsp_data=0, fault=1.
- Store writes:
  - WD: all lanes.
  - Half: lanes a,b if addr[1]=0, else lanes c,d; written with data_in[15:0].
  - Byte: only the lane selected by addr[1:0], written with data_in[7:0].
  - Unsigned and signed half/byte ops store identically.
- Load extraction:
  - Half: lanes b:a if addr[1]=0, else d:c.
  - Byte: lane selected by addr[1:0].
  - UH/UB zero-extend; SH/SB replicate bit 7 of the top selected byte.
- data_dbg reads the array contents before the current edge's write. It ignores addr_dbg[1:0] and wraps on the upper bits.

## Timing
- Reset values: ready=0, rsp_valid=0, rsp_data=0, fault=0. FSM=INIT, counter=0.
- Init duration: 2^ADDR_BITS cycles (INIT_CLEAR=1) or 1 cycle (INIT_CLEAR=0) from the first cycle with rst_n=1 until ready=1.
- Latency: a request accepted at edge N gives rsp_valid=1 with rsp_data/fault during the cycle after edge N, until edge N+1.
- A store writes the array at edge N.
- Throughput: one request per cycle, back-to-back.
- A load at edge N+1 to a word stored at edge N returns the new data.
- Lanes not written by a partial store keep their prior value.
- When no request is accepted: rsp_valid=0 next cycle, and rsp_data/fault hold their last values.
- Reset mid-operation: a pending response is dropped (rsp_valid=0 next cycle) and INIT restarts from counter 0. A store accepted at the same edge reset is sampled low is not performed.

## Test plan
- Reset, ADDR_BITS=4, INIT_CLEAR=1 → ready low exactly 16 cycles, then high; every data_dbg word reads 0x00000000.
- Store WD 0x8899AABC at 0x8, then loads at 0x8: UB → 0x000000BC, SB addr 0x9 → 0xFFFFFFAA, UH addr 0xA → 0x00008899, SH addr 0xA → 0xFFFF8899, WD → 0x8899AABC, each with one-cycle latency.
- Store SB 0x55 at 0xB after the above → WD load at 0x8 returns 0x5599AABC.
- Back-to-back store WD 0x12345678 at 0x4 then load WD at 0x4 on the next cycle → rsp_data 0x12345678, fault 0.
- Faulting requests → fault=1, rsp_data=0, word unchanged:
  - WD at 0x2
  - SH at 0x1
  - WD at 0x40 with ADDR_BITS=4
  - illegal op code
- Reset asserted the cycle after a load is accepted → no rsp_valid. Ready returns 16 cycles after release and memory is re-cleared to 0.
